// File: rtl/bundle_relay_if.sv
`default_nettype none
// ============================================================================
//  Module   : bundle_relay_if
//  Purpose  : Signal bundle carried between producer and consumer through the
//             elastic relay: valid/ready handshake on each side, flag, tag,
//             packed and unpacked byte-lane data, flush, occupancy and
//             high-water mark.
//  Modports : slave  - seen by the relay (consumes i_*, drives o_*/i_ready)
//             master - seen by the surrounding logic driving the relay
//  Revision : 1.0 - initial release
// ============================================================================
interface bundle_relay_if #(
    parameter int LANES  = 3,
    parameter int BYTE_W = 8,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // producer side
    logic                          i_flush;
    logic                          i_valid;
    logic                          i_ready;
    logic                          i_flag;
    logic [TAG_W-1:0]              i_tag;
    logic [0:LANES-1][BYTE_W-1:0]  i_pdata;
    logic [BYTE_W-1:0]             i_udata [0:LANES-1];

    // consumer side
    logic                          o_valid;
    logic                          o_ready;
    logic                          o_flag;
    logic [TAG_W-1:0]              o_tag;
    logic [0:LANES-1][BYTE_W-1:0]  o_pdata;
    logic [BYTE_W-1:0]             o_udata [0:LANES-1];

    // status
    logic [CNT_W-1:0]              o_count;
    logic [CNT_W-1:0]              o_hwm;

    modport slave (
        input  i_flush, i_valid, i_flag, i_tag, i_pdata, i_udata, o_ready,
        output i_ready, o_valid, o_flag, o_tag, o_pdata, o_udata, o_count, o_hwm
    );

    modport master (
        output i_flush, i_valid, i_flag, i_tag, i_pdata, i_udata, o_ready,
        input  i_ready, o_valid, o_flag, o_tag, o_pdata, o_udata, o_count, o_hwm
    );
endinterface
`default_nettype wire

// File: rtl/bundle_relay.sv
`default_nettype none
// ============================================================================
//  Module   : bundle_relay
//  Purpose  : Elastic valid/ready relay for the flag/tag/byte-lane bundle.
//             Circular buffer of DEPTH entries with occupancy count,
//             high-water mark, synchronous flush and optional zero-latency
//             bypass when empty (PASS_THRU=1).
//  Ports    : clk  - single clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - bundle_relay_if.slave (handshakes, fields, status)
//  Revision : 1.0 - initial release
// ============================================================================
module bundle_relay #(
    parameter int LANES     = 3,
    parameter int BYTE_W    = 8,
    parameter int TAG_W     = 2,
    parameter int DEPTH     = 4,
    parameter int PASS_THRU = 0
) (
    input  logic               clk,
    input  logic               rst,
    bundle_relay_if.slave      bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [0:LANES-1][BYTE_W-1:0] lanes_t;

    // Unpacked lanes are folded into a packed vector so a beat is one word.
    typedef struct packed {
        logic             flag;
        logic [TAG_W-1:0] tag;
        lanes_t           pdata;
        lanes_t           udata;
    } beat_t;

    beat_t            mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hwm;
    logic [CNT_W-1:0] count_nxt;

    beat_t in_beat;
    beat_t head_beat;
    beat_t out_beat;
    logic  empty;
    logic  full;
    logic  can_accept;
    logic  bypass;
    logic  push;
    logic  pop;
    logic  store;

    // ---------------------------------------------------------------- input
    assign in_beat.flag  = bus.i_flag;
    assign in_beat.tag   = bus.i_tag;
    assign in_beat.pdata = bus.i_pdata;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign in_beat.udata[k] = bus.i_udata[k];
        assign bus.o_udata[k]   = out_beat.udata[k];
    end

    // ------------------------------------------------------------ handshake
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Acceptance looks only at registered occupancy; a pop in the same cycle
    // never frees a slot for a push while full.
    assign can_accept  = !full && !bus.i_flush && !rst;
    assign bus.i_ready = can_accept;

    assign push = bus.i_valid && can_accept;
    assign pop  = !empty && bus.o_ready;

    if (PASS_THRU != 0) begin : g_bypass
        // Beat goes straight through and is never written to storage.
        assign bypass = empty && push && bus.o_ready;
    end else begin : g_no_bypass
        assign bypass = 1'b0;
    end

    assign store = push && !bypass;

    always_comb begin
        count_nxt = count;
        if (store && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !store) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // --------------------------------------------------------------- output
    assign head_beat = mem[rd_ptr];
    // When empty the output only matters during bypass, so the input bundle
    // is selected there; otherwise the head of the buffer is presented.
    assign out_beat  = empty ? in_beat : head_beat;

    assign bus.o_valid = !empty || bypass;
    assign bus.o_flag  = out_beat.flag;
    assign bus.o_tag   = out_beat.tag;
    assign bus.o_pdata = out_beat.pdata;
    assign bus.o_count = count;
    assign bus.o_hwm   = hwm;

    // -------------------------------------------------------------- storage
    // Payload RAM is intentionally not reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= in_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hwm    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            if (count_nxt > hwm) begin
                hwm <= count_nxt;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bundle_relay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bundle_relay
//  Purpose  : Self-checking bench for bundle_relay. Two relays (storage only
//             and bypass-enabled) receive identical stimulus; a queue-based
//             model of each is compared against the outputs every cycle, and
//             directed phases pin literal values from the scenario list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bundle_relay;
    localparam int LANES  = 3;
    localparam int BYTE_W = 8;
    localparam int TAG_W  = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef logic [0:LANES-1][BYTE_W-1:0] pk_t;
    typedef struct packed {
        logic             flag;
        logic [TAG_W-1:0] tag;
        pk_t              p;
        pk_t              u;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             drv_valid, drv_flag, drv_ordy, drv_flush;
    logic [TAG_W-1:0] drv_tag;
    pk_t              drv_pdata, drv_udata;

    int vectors     = 0;
    int miscompares = 0;

    bundle_relay_if #(.LANES(LANES), .BYTE_W(BYTE_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) if0 ();
    bundle_relay_if #(.LANES(LANES), .BYTE_W(BYTE_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) if1 ();

    assign if0.i_valid = drv_valid;  assign if1.i_valid = drv_valid;
    assign if0.i_flag  = drv_flag;   assign if1.i_flag  = drv_flag;
    assign if0.i_tag   = drv_tag;    assign if1.i_tag   = drv_tag;
    assign if0.i_pdata = drv_pdata;  assign if1.i_pdata = drv_pdata;
    assign if0.o_ready = drv_ordy;   assign if1.o_ready = drv_ordy;
    assign if0.i_flush = drv_flush;  assign if1.i_flush = drv_flush;
    for (genvar k = 0; k < LANES; k++) begin : g_udrv
        assign if0.i_udata[k] = drv_udata[k];
        assign if1.i_udata[k] = drv_udata[k];
    end

    bundle_relay #(.LANES(LANES), .BYTE_W(BYTE_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .PASS_THRU(0))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    bundle_relay #(.LANES(LANES), .BYTE_W(BYTE_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .PASS_THRU(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    // ------------------------------------------------------------- model
    beat_t q0[$];
    beat_t q1[$];
    int    hwm0 = 0;
    int    hwm1 = 0;

    task automatic model_check(input int d, input logic ov, input logic ir,
                               input logic of, input logic [TAG_W-1:0] ot,
                               input pk_t op, input pk_t ou,
                               input logic [CNT_W-1:0] oc, input logic [CNT_W-1:0] oh);
        beat_t q[$];
        beat_t e, inb;
        int    h;
        logic  exp_ir, exp_ov, byp;
        if (d == 0) begin q = q0; h = hwm0; end
        else        begin q = q1; h = hwm1; end
        inb = '{flag: drv_flag, tag: drv_tag, p: drv_pdata, u: drv_udata};
        exp_ir = !rst && !drv_flush && (q.size() < DEPTH);
        byp    = (d == 1) && (q.size() == 0) && drv_valid && drv_ordy && exp_ir;
        exp_ov = (q.size() != 0) || byp;
        chk($sformatf("d%0d_i_ready", d), 64'(ir), 64'(exp_ir));
        chk($sformatf("d%0d_o_valid", d), 64'(ov), 64'(exp_ov));
        chk($sformatf("d%0d_o_count", d), 64'(oc), 64'(q.size()));
        chk($sformatf("d%0d_o_hwm", d),   64'(oh), 64'(h));
        if (exp_ov) begin
            e = (q.size() != 0) ? q[0] : inb;
            chk($sformatf("d%0d_o_flag", d),  64'(of), 64'(e.flag));
            chk($sformatf("d%0d_o_tag", d),   64'(ot), 64'(e.tag));
            chk($sformatf("d%0d_o_pdata", d), 64'(op), 64'(e.p));
            chk($sformatf("d%0d_o_udata", d), 64'(ou), 64'(e.u));
        end
        // advance to the state after the coming edge
        if (rst || drv_flush) begin
            q.delete();
            h = 0;
        end else if (!byp) begin
            if (exp_ov && drv_ordy) void'(q.pop_front());
            if (drv_valid && exp_ir) q.push_back(inb);
            if (q.size() > h) h = q.size();
        end
        if (d == 0) begin q0 = q; hwm0 = h; end
        else        begin q1 = q; hwm1 = h; end
    endtask

    always @(negedge clk) begin
        pk_t u0, u1;
        for (int k = 0; k < LANES; k++) begin
            u0[k] = if0.o_udata[k];
            u1[k] = if1.o_udata[k];
        end
        model_check(0, if0.o_valid, if0.i_ready, if0.o_flag, if0.o_tag, if0.o_pdata, u0, if0.o_count, if0.o_hwm);
        model_check(1, if1.o_valid, if1.i_ready, if1.o_flag, if1.o_tag, if1.o_pdata, u1, if1.o_count, if1.o_hwm);
    end

    // ---------------------------------------------------------- stimulus
    task automatic rand_data();
        drv_flag = 1'($urandom);
        drv_tag  = TAG_W'($urandom);
        for (int k = 0; k < LANES; k++) begin
            drv_pdata[k] = BYTE_W'($urandom);
            drv_udata[k] = BYTE_W'($urandom);
        end
    endtask

    task automatic do_flush();
        @(posedge clk); #1; rst = 1'b0; drv_flush = 1'b1; drv_valid = 1'b0;
        @(posedge clk); #1; drv_flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; drv_valid = 1'b0; drv_ordy = 1'b0; drv_flush = 1'b0;
        drv_flag = 1'b0; drv_tag = '0; drv_pdata = '0; drv_udata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ready0", 64'(if0.i_ready), 64'd0);
        chk("rst_i_ready1", 64'(if1.i_ready), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_i_ready", 64'(if0.i_ready), 64'd1);
        chk("post_rst_o_valid", 64'(if0.o_valid), 64'd0);
        chk("post_rst_count",   64'(if0.o_count), 64'd0);
        chk("post_rst_hwm",     64'(if0.o_hwm),   64'd0);

        // single beat; bypass relay forwards it in the same cycle
        @(posedge clk); #1;
        drv_valid = 1'b1; drv_ordy = 1'b1; drv_flag = 1'b1; drv_tag = 2'b10;
        drv_pdata = {8'hA0, 8'hA1, 8'hA2}; drv_udata = {8'h10, 8'h11, 8'h12};
        @(negedge clk);
        chk("byp_o_valid", 64'(if1.o_valid), 64'd1);
        chk("byp_o_tag",   64'(if1.o_tag),   64'd2);
        chk("byp_count",   64'(if1.o_count), 64'd0);
        chk("single_lat0", 64'(if0.o_valid), 64'd0);
        @(posedge clk); #1; drv_valid = 1'b0;
        @(negedge clk);
        chk("single_valid",  64'(if0.o_valid),    64'd1);
        chk("single_flag",   64'(if0.o_flag),     64'd1);
        chk("single_tag",    64'(if0.o_tag),      64'd2);
        chk("single_p0",     64'(if0.o_pdata[0]), 64'hA0);
        chk("single_p2",     64'(if0.o_pdata[2]), 64'hA2);
        chk("single_u0",     64'(if0.o_udata[0]), 64'h10);
        chk("single_u2",     64'(if0.o_udata[2]), 64'h12);
        chk("single_count1", 64'(if0.o_count),    64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("single_count0", 64'(if0.o_count), 64'd0);
        chk("single_hwm",    64'(if0.o_hwm),   64'd1);
        chk("byp_hwm",       64'(if1.o_hwm),   64'd0);

        // bypass relay, consumer stalled: beat is stored instead
        @(posedge clk); #1; drv_valid = 1'b1; drv_ordy = 1'b0; drv_tag = 2'b01;
        @(negedge clk);
        chk("store_no_valid", 64'(if1.o_valid), 64'd0);
        @(posedge clk); #1; drv_valid = 1'b0;
        @(negedge clk);
        chk("store_valid", 64'(if1.o_valid), 64'd1);
        chk("store_tag",   64'(if1.o_tag),   64'd1);
        chk("store_count", 64'(if1.o_count), 64'd1);
        do_flush();

        // fill past capacity with consumer stalled
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; drv_valid = 1'b1; rand_data();
            if (i == 4) begin
                @(negedge clk);
                chk("fill_i_ready", 64'(if0.i_ready), 64'd0);
                chk("fill_count",   64'(if0.o_count), 64'd4);
            end
        end
        @(posedge clk); #1; drv_valid = 1'b0;
        @(negedge clk);
        chk("fill_hwm",   64'(if0.o_hwm),   64'd4);
        chk("fill_count5", 64'(if0.o_count), 64'd4);

        // full with simultaneous pop: pop only
        @(posedge clk); #1; drv_valid = 1'b1; drv_ordy = 1'b1; rand_data();
        @(negedge clk);
        chk("full_pop_i_ready", 64'(if0.i_ready), 64'd0);
        @(posedge clk); #1; drv_ordy = 1'b0;
        @(negedge clk);
        chk("full_pop_count", 64'(if0.o_count), 64'd3);
        @(posedge clk); #1; drv_valid = 1'b0;
        @(negedge clk);
        chk("refill_count", 64'(if0.o_count), 64'd4);
        @(posedge clk); #1; drv_ordy = 1'b1;
        @(posedge clk); #1; drv_ordy = 1'b0;

        // flush at count 3 with an offered beat
        @(posedge clk); #1; drv_flush = 1'b1; drv_valid = 1'b1;
        @(negedge clk);
        chk("flush_count_pre", 64'(if0.o_count), 64'd3);
        chk("flush_i_ready",   64'(if0.i_ready), 64'd0);
        @(posedge clk); #1; drv_flush = 1'b0; drv_valid = 1'b0;
        @(negedge clk);
        chk("flush_o_valid", 64'(if0.o_valid), 64'd0);
        chk("flush_count",   64'(if0.o_count), 64'd0);
        chk("flush_hwm",     64'(if0.o_hwm),   64'd0);

        // randomized traffic, wrap-around, occasional flush/reset
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            drv_valid = ($urandom_range(0, 9) < 7);
            drv_ordy  = ($urandom_range(0, 9) < 6);
            drv_flush = ($urandom_range(0, 99) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            rand_data();
        end
        @(posedge clk); #1; rst = 1'b0; drv_flush = 1'b0; drv_valid = 1'b0; drv_ordy = 1'b0;
        do_flush();

        // reset mid-drain at count 2
        repeat (2) begin
            @(posedge clk); #1; drv_valid = 1'b1; rand_data();
        end
        @(posedge clk); #1; drv_valid = 1'b0; drv_ordy = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_count_pre", 64'(if0.o_count), 64'd2);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_o_valid", 64'(if0.o_valid), 64'd0);
        chk("rst_mid_count",   64'(if0.o_count), 64'd0);
        chk("rst_mid_valid1",  64'(if1.o_valid), 64'd0);
        repeat (5) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bundle_relay.md
# bundle_relay

Parametrised, elastic relay for the producer-to-consumer signal bundle (1-bit flag, narrow tag, packed byte-lane array, unpacked byte-lane array) carried between sibling submodules at top level. It replaces the bare wire connection with a valid/ready FIFO of configurable depth, lane count and widths. It adds an optional zero-latency bypass, a synchronous flush, occupancy reporting and a high-water mark. It sits between the `s1`-style producer and the `s2`-style consumer and preserves lane ordering bit-exactly.

## Interface
- `LANES`, 3: byte lanes per beat, ≥1
- `BYTE_W`, 8: bits per lane
- `TAG_W`, 2: tag width, ≥1
- `DEPTH`, 4: storage entries, power of two, ≥2
- `PASS_THRU`, 0: 1 = bypass storage when empty and downstream ready
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous reset, active-high
- `i_flush` in 1: synchronous flush, discards all stored beats
- `i_valid` in 1: producer beat valid
- `i_ready` out 1: relay can accept
- `i_flag` in 1: single-bit field
- `i_tag` in TAG_W: tag field
- `i_pdata` in [0:LANES-1][BYTE_W-1:0]: packed lane data
- `i_udata` in [BYTE_W-1:0] x [0:LANES-1]: unpacked lane data
- `o_valid` out 1: consumer beat valid
- `o_ready` in 1: consumer accepts
- `o_flag`, `o_tag`, `o_pdata`, `o_udata` out: same shapes as inputs
- `o_count` out $clog2(DEPTH)+1: stored entries, 0..DEPTH
- `o_hwm` out $clog2(DEPTH)+1: maximum `o_count` since reset/flush

## Operation
- push = `i_valid & i_ready`; pop = `o_valid & o_ready`.
- Storage is a circular buffer with write/read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
- `i_ready` = (count < DEPTH) & !`i_flush`. Registered count only, no combinational path from `o_ready`: when full, simultaneous pop does not enable push that cycle.
- PASS_THRU=0: `o_valid` = (count != 0); output fields = entry at read pointer.
- PASS_THRU=1: when count==0 and `i_valid` and `o_ready`, the input fields drive the outputs combinationally. `o_valid`=1, the beat is not stored, and count is unchanged. When count==0 and `o_ready`=0, the beat is stored normally.
- Count update: push&!pop +1; pop&!push −1; both → unchanged, both pointers advance.
- Field fidelity: lane k of `i_pdata` → lane k of `o_pdata`; index k of `i_udata` → index k of `o_udata`. No reordering, no byte swap.
- `o_hwm` <= max(`o_hwm`, next count) every cycle; saturates at DEPTH.
- Flush: next cycle count=0, pointers=0, `o_hwm`=0. Flush beats pop and push in the same cycle. An input beat offered during flush is not accepted (`i_ready`=0). Bypass is disabled during flush (`o_valid`=0).
- Reset: identical to flush. Also asserted mid-transfer, it discards all content. Storage RAM contents are not reset.

## Timing
- Reset values: `o_valid`=0, `i_ready`=0 while `rst` high and 1 in the first cycle after, `o_count`=0, `o_hwm`=0. Data outputs are don't-care while `o_valid`=0.
- Latency, PASS_THRU=0: a push at edge N gives `o_valid`=1 in cycle N+1 (1 cycle).
- Latency, PASS_THRU=1 bypass: 0 cycles. Stored path: 1 cycle.
- Throughput: 1 beat/cycle sustained when 0<count<DEPTH.
- Data at `o_*` is stable while `o_valid`=1 and `o_ready`=0.
- `o_count` and `o_hwm` are registered and reflect state after the previous edge.

## Test plan
- Reset then single beat (flag=1, tag=2'b10, pdata={8'hA0,8'hA1,8'hA2}, udata={8'h10,8'h11,8'h12}) with `o_ready`=1 → `o_valid` one cycle later with identical fields per lane; `o_count` goes 1→0; `o_hwm`=1.
- Fill: `o_ready`=0, push 5 beats with DEPTH=4 → 4 accepted, `i_ready`=0 after the 4th, `o_count`=4, `o_hwm`=4. Then drain → beats emerge in order, each held stable across stall cycles.
- Full with simultaneous pop: count=4, `i_valid`=1, `o_ready`=1 → pop only, count=3. The next cycle accepts the push, and the wrap-around pointer delivers correct order over 10 beats.
- PASS_THRU=1, empty, `o_ready`=1, tag=2'b01 → same-cycle `o_valid`=1 with tag 2'b01, `o_count` stays 0. With `o_ready`=0, the beat is stored and appears next cycle.
- Flush while count=3 and `i_valid`=1 → `i_ready`=0 that cycle; next cycle `o_valid`=0, `o_count`=0, `o_hwm`=0. The following push is delivered normally.
- `rst` asserted mid-drain (count=2) → next cycle count=0 and `o_valid`=0. No stale beat appears after reset.
